// File: rtl/mackerel_bus_ctrl.sv
// mackerel_bus_ctrl
//   Sequences every 68000 bus cycle on the Mackerel board. It replaces the
//   decoder's combinational DTACK OR with a registered controller that:
//     - generates a wait-stated DTACK for ROM, RAM and USB,
//     - relays the MFP and serial DTACKs,
//     - raises BERR from a watchdog when nothing answers.
//
// Build option:
//   MACKEREL_AUTOVEC_EN - An unanswered IACK cycle is autovectored with VPA
//                         after AUTOVEC_WAIT cycles. It never raises BERR.
//                         Without this macro VPA stays high permanently.
//
// Ports (all active-low unless noted):
//   CLK         in   CPU clock; all logic on posedge
//   RST         in   synchronous reset, active-high
//   AS          in   address strobe (already synchronous)
//   IACK        in   interrupt-acknowledge cycle
//   ROMEN       in   ROM select
//   RAMEN       in   RAM select (any bank)
//   MFPEN       in   MFP select
//   SEREN       in   serial select
//   USBEN       in   USB select
//   DTACK_MFP   in   MFP DTACK
//   DTACK_SER   in   serial DTACK
//   DTACK       out  to CPU, registered
//   BERR        out  to CPU, registered
//   VPA         out  to CPU, registered
//   CYCLE_STATE out  [1:0] state for debug/LEDs (0 IDLE, 1 WAIT, 2 ACK, 3 ERR)
module mackerel_bus_ctrl #(
   parameter int ROM_WAIT     = 2,
   parameter int RAM_WAIT     = 0,
   parameter int USB_WAIT     = 4,
   parameter int TIMEOUT      = 64,
   parameter int AUTOVEC_WAIT = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       AS,
   input  logic       IACK,
   input  logic       ROMEN,
   input  logic       RAMEN,
   input  logic       MFPEN,
   input  logic       SEREN,
   input  logic       USBEN,
   input  logic       DTACK_MFP,
   input  logic       DTACK_SER,
   output logic       DTACK,
   output logic       BERR,
   output logic       VPA,
   output logic [1:0] CYCLE_STATE
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ROM  = 3'd1,
      CLS_RAM  = 3'd2,
      CLS_MFP  = 3'd3,
      CLS_SER  = 3'd4,
      CLS_USB  = 3'd5
   } cls_t;

   localparam logic [7:0] ROM_LOAD = 8'(ROM_WAIT);
   localparam logic [7:0] RAM_LOAD = 8'(RAM_WAIT);
   localparam logic [7:0] USB_LOAD = 8'(USB_WAIT);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
`ifdef MACKEREL_AUTOVEC_EN
   localparam logic [7:0] AV_LAST  = 8'(AUTOVEC_WAIT - 1);
`endif

   // Reject parameter sets the watchdog cannot represent.
   if (TIMEOUT < 2 || TIMEOUT > 255 || AUTOVEC_WAIT < 1 || AUTOVEC_WAIT >= TIMEOUT) begin : g_bad_params
      $error("mackerel_bus_ctrl: TIMEOUT must be 2..255 and AUTOVEC_WAIT 1..TIMEOUT-1");
   end

   state_t     state_r;
   cls_t       cls_r;
   logic [7:0] wait_cnt_r;
   logic [7:0] wd_cnt_r;
`ifdef MACKEREL_AUTOVEC_EN
   logic       iack_r;
`endif

   cls_t       next_cls_s;
   logic [7:0] load_s;
   logic       ack_s;
   logic       autovec_s;
   logic       timeout_s;

   // Classify the new cycle; an IACK cycle is answered by the MFP.
   always_comb begin
      next_cls_s = CLS_NONE;
      if (!IACK) begin
         next_cls_s = CLS_MFP;
      end else if (!ROMEN) begin
         next_cls_s = CLS_ROM;
      end else if (!RAMEN) begin
         next_cls_s = CLS_RAM;
      end else if (!MFPEN) begin
         next_cls_s = CLS_MFP;
      end else if (!SEREN) begin
         next_cls_s = CLS_SER;
      end else if (!USBEN) begin
         next_cls_s = CLS_USB;
      end else begin
         next_cls_s = CLS_NONE;
      end
   end

   // Wait-state preload; non-timed classes load zero so the countdown is a no-op.
   always_comb begin
      load_s = 8'd0;
      case (next_cls_s)
         CLS_ROM: load_s = ROM_LOAD;
         CLS_RAM: load_s = RAM_LOAD;
         CLS_USB: load_s = USB_LOAD;
         default: load_s = 8'd0;
      endcase
   end

   // Acknowledge condition for the captured class; other DTACK inputs are ignored.
   always_comb begin
      ack_s = 1'b0;
      case (cls_r)
         CLS_ROM, CLS_RAM, CLS_USB: ack_s = (wait_cnt_r == 8'd0);
         CLS_MFP:                   ack_s = !DTACK_MFP;
         CLS_SER:                   ack_s = !DTACK_SER;
         default:                   ack_s = 1'b0;
      endcase
   end

   // Watchdog outcomes; an IACK cycle autovectors instead of erroring when enabled.
   always_comb begin
`ifdef MACKEREL_AUTOVEC_EN
      autovec_s = iack_r && (wd_cnt_r == AV_LAST);
      timeout_s = !iack_r && (wd_cnt_r == TO_LAST);
`else
      autovec_s = 1'b0;
      timeout_s = (wd_cnt_r == TO_LAST);
`endif
   end

   // Bus-cycle state machine with registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= ST_IDLE;
         cls_r      <= CLS_NONE;
         wait_cnt_r <= 8'd0;
         wd_cnt_r   <= 8'd0;
         DTACK      <= 1'b1;
         BERR       <= 1'b1;
         VPA        <= 1'b1;
`ifdef MACKEREL_AUTOVEC_EN
         iack_r     <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!AS) begin
                  state_r    <= ST_WAIT;
                  cls_r      <= next_cls_s;
                  wait_cnt_r <= load_s;
                  wd_cnt_r   <= 8'd0;
`ifdef MACKEREL_AUTOVEC_EN
                  iack_r     <= !IACK;
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (AS) begin
                  // CPU abandoned the cycle: leave quietly.
                  state_r <= ST_IDLE;
               end else if (ack_s) begin
                  state_r <= ST_ACK;
                  DTACK   <= 1'b0;
               end else if (autovec_s) begin
                  state_r <= ST_ACK;
                  VPA     <= 1'b0;
               end else if (timeout_s) begin
                  state_r <= ST_ERR;
                  BERR    <= 1'b0;
               end else begin
                  if (wd_cnt_r != 8'hFF) begin
                     wd_cnt_r <= wd_cnt_r + 8'd1;
                  end else begin
                     wd_cnt_r <= wd_cnt_r;
                  end
                  if (wait_cnt_r != 8'd0) begin
                     wait_cnt_r <= wait_cnt_r - 8'd1;
                  end else begin
                     wait_cnt_r <= wait_cnt_r;
                  end
               end
            end
            ST_ACK, ST_ERR: begin
               // Hold the response until the CPU drops AS.
               if (AS) begin
                  state_r <= ST_IDLE;
                  DTACK   <= 1'b1;
                  BERR    <= 1'b1;
                  VPA     <= 1'b1;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               DTACK   <= 1'b1;
               BERR    <= 1'b1;
               VPA     <= 1'b1;
            end
         endcase
      end
   end

   assign CYCLE_STATE = state_r;

endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// Testbench for mackerel_bus_ctrl. Each bus cycle is described by its selects,
// the edge at which the matching peripheral DTACK goes low, and the edge at
// which AS is seen high again. Expected outputs follow from the edge arithmetic
// of the bus rules (response edge, response kind, release edge).
module tb_mackerel_bus_ctrl;

   localparam int ROM_W = 2;
   localparam int RAM_W = 0;
   localparam int USB_W = 4;
   localparam int TO    = 64;
   localparam int AV    = 8;
`ifdef MACKEREL_AUTOVEC_EN
   localparam bit AUTOVEC = 1'b1;
`else
   localparam bit AUTOVEC = 1'b0;
`endif

   // Response kinds
   localparam int K_NONE  = 0;
   localparam int K_DTACK = 1;
   localparam int K_BERR  = 2;
   localparam int K_VPA   = 3;

   logic       CLK, RST, AS, IACK, ROMEN, RAMEN, MFPEN, SEREN, USBEN;
   logic       DTACK_MFP, DTACK_SER;
   logic       DTACK, BERR, VPA;
   logic [1:0] CYCLE_STATE;

   int n_checks = 0;
   int n_pass   = 0;

   mackerel_bus_ctrl #(
      .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .USB_WAIT(USB_W),
      .TIMEOUT(TO), .AUTOVEC_WAIT(AV)
   ) dut (
      .CLK(CLK), .RST(RST), .AS(AS), .IACK(IACK),
      .ROMEN(ROMEN), .RAMEN(RAMEN), .MFPEN(MFPEN), .SEREN(SEREN), .USBEN(USBEN),
      .DTACK_MFP(DTACK_MFP), .DTACK_SER(DTACK_SER),
      .DTACK(DTACK), .BERR(BERR), .VPA(VPA), .CYCLE_STATE(CYCLE_STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // sel = {ROMEN, RAMEN, MFPEN, SEREN, USBEN}, active-low
   typedef struct {
      string      name;
      logic [4:0] sel;
      logic       iack;
      int         ext_at;
      int         hold;
      int         exp_t;
      int         exp_kind;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string name, input logic [4:0] sel, input logic iack,
                          input int ext_at, input int hold, input int t, input int kind);
      vec_t v;
      v.name = name; v.sel = sel; v.iack = iack; v.ext_at = ext_at;
      v.hold = hold; v.exp_t = t; v.exp_kind = kind;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {DTACK, BERR, VPA, CYCLE_STATE};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: DTACK/BERR/VPA/STATE got %b expected %b", name, act, exp);
   endtask

   // Expected {DTACK,BERR,VPA,STATE} after edge k of a cycle.
   function automatic logic [4:0] expect_at(input int k, input int t, input int kind, input int hold);
      if (k >= hold) return 5'b111_00;
      if (kind == K_NONE || k < t) return 5'b111_01;
      case (kind)
         K_DTACK: return 5'b011_10;
         K_BERR:  return 5'b101_11;
         default: return 5'b110_10;
      endcase
   endfunction

   // Reference: which edge (relative to AS first sampled low) answers the cycle, and how.
   task automatic predict(input logic [4:0] sel, input logic iack, input int ext_at,
                          input int hold, output int t, output int kind);
      int wd_t, wd_kind;
      t = 1 << 20; kind = K_NONE;
      if (!iack || (sel[4:3] == 2'b11 && !sel[2]) || (sel[4:1] == 4'b1111 && !sel[0] ? 1'b0 : 1'b0)) begin
         // MFP class (IACK or MFP select winning priority)
         if (ext_at >= 0) begin t = (ext_at < 1) ? 1 : ext_at; kind = K_DTACK; end
      end else if (!sel[4]) begin
         t = 1 + ROM_W; kind = K_DTACK;
      end else if (!sel[3]) begin
         t = 1 + RAM_W; kind = K_DTACK;
      end else if (!sel[1]) begin
         if (ext_at >= 0) begin t = (ext_at < 1) ? 1 : ext_at; kind = K_DTACK; end
      end else if (!sel[0]) begin
         t = 1 + USB_W; kind = K_DTACK;
      end
      if (AUTOVEC && !iack) begin wd_t = AV; wd_kind = K_VPA; end
      else begin wd_t = TO; wd_kind = K_BERR; end
      if (wd_t < t) begin t = wd_t; kind = wd_kind; end
      if (t >= hold) kind = K_NONE;
   endtask

   // Run one bus cycle starting at the next edge, checking after every edge.
   task automatic run_cycle(input string name, input logic [4:0] sel, input logic iack,
                            input int ext_at, input int hold, input int t, input int kind);
      logic mfp_match, ser_match, mline;
      mfp_match = !iack || (sel[4:3] == 2'b11 && !sel[2]);
      ser_match = iack && (sel[4:2] == 3'b111) && !sel[1];
      for (int k = 0; k <= hold; k++) begin
         AS    = (k < hold) ? 1'b0 : 1'b1;
         IACK  = iack;
         {ROMEN, RAMEN, MFPEN, SEREN, USBEN} = sel;
         mline = (ext_at >= 0 && k >= ext_at) ? 1'b0 : 1'b1;
         DTACK_MFP = mfp_match ? mline : 1'($urandom_range(0, 1));
         DTACK_SER = ser_match ? mline : 1'($urandom_range(0, 1));
         @(posedge CLK);
         @(negedge CLK);
         check($sformatf("%s@%0d", name, k), expect_at(k, t, kind, hold));
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         AS = 1'b1;
         DTACK_MFP = 1'($urandom_range(0, 1));
         DTACK_SER = 1'($urandom_range(0, 1));
         @(posedge CLK);
         @(negedge CLK);
         check("idle", 5'b111_00);
      end
   endtask

   initial begin
      logic [4:0] sel;
      logic       iack;
      int         ext_at, hold, t, kind;

      RST = 1'b1; AS = 1'b1; IACK = 1'b1;
      {ROMEN, RAMEN, MFPEN, SEREN, USBEN} = 5'b11111;
      DTACK_MFP = 1'b1; DTACK_SER = 1'b1;

      // Table: name, sel, iack, ext_at, hold, expected edge, expected kind
      add_vec("ram",          5'b10111, 1'b1, -1,  4,  1, K_DTACK);
      add_vec("rom_over_ram", 5'b00111, 1'b1, -1,  6,  3, K_DTACK);
      add_vec("usb",          5'b11110, 1'b1, -1,  8,  5, K_DTACK);
      add_vec("usb_abort",    5'b11110, 1'b1, -1,  3,  5, K_NONE);
      add_vec("mfp",          5'b11011, 1'b1,  5,  8,  5, K_DTACK);
      add_vec("ser",          5'b11101, 1'b1,  2,  5,  2, K_DTACK);
      add_vec("mfp_early",    5'b11011, 1'b1,  0,  4,  1, K_DTACK);
      add_vec("unmapped",     5'b11111, 1'b1, -1, 67, 64, K_BERR);
`ifdef MACKEREL_AUTOVEC_EN
      add_vec("iack_noans",   5'b11111, 1'b0, -1, 12,  8, K_VPA);
`else
      add_vec("iack_noans",   5'b11111, 1'b0, -1, 67, 64, K_BERR);
`endif
      add_vec("iack_mfp",     5'b11111, 1'b0,  3,  6,  3, K_DTACK);
      add_vec("ack_vs_to",    5'b11011, 1'b1, 64, 67, 64, K_DTACK);
      add_vec("late_mfp",     5'b11011, 1'b1, 65, 67, 64, K_BERR);
      add_vec("unmap_abort",  5'b11111, 1'b1, -1, 10, 64, K_NONE);
      add_vec("ram_short",    5'b10111, 1'b1, -1,  1,  1, K_NONE);

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset", 5'b111_00);
      RST = 1'b0;

      foreach (vecs[i])
         run_cycle(vecs[i].name, vecs[i].sel, vecs[i].iack, vecs[i].ext_at,
                   vecs[i].hold, vecs[i].exp_t, vecs[i].exp_kind);
      idle(2);

      // Reset while DTACK is asserted, then a clean restart.
      AS = 1'b0; IACK = 1'b1; {ROMEN, RAMEN, MFPEN, SEREN, USBEN} = 5'b10111;
      @(posedge CLK); @(negedge CLK);
      check("rst_seq_wait", 5'b111_01);
      @(posedge CLK); @(negedge CLK);
      check("rst_seq_ack", 5'b011_10);
      RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      check("rst_in_ack", 5'b111_00);
      RST = 1'b0; AS = 1'b1;
      @(posedge CLK); @(negedge CLK);
      check("rst_release", 5'b111_00);
      run_cycle("after_rst", 5'b10111, 1'b1, -1, 3, 1, K_DTACK);

      // Random cycles against the reference.
      for (int i = 0; i < 40; i++) begin
         for (int b = 0; b < 5; b++) sel[b] = ($urandom_range(0, 2) != 0);
         iack   = ($urandom_range(0, 7) != 0);
         ext_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 12));
         hold   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(60, 70))
                                              : int'($urandom_range(1, 12));
         predict(sel, iack, ext_at, hold, t, kind);
         run_cycle($sformatf("rnd%0d", i), sel, iack, ext_at, hold, t, kind);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
